// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one byte-wide instruction memory between a fetch
// read port and a loader write port. Each granted request moves one 32-bit
// word as four big-endian byte cycles, followed by an IDLE cycle that
// carries the valid/done pulse and may accept the next grant.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_f_req/i_f_addr                  fetch request and byte address
//   o_f_gnt                           fetch accepted (combinational, IDLE only)
//   o_f_valid/o_f_rdata               read-complete pulse and held word
//   i_l_req/i_l_addr/i_l_wdata        loader write request, address, word
//   o_l_gnt                           loader accepted (combinational, IDLE only)
//   o_l_done                          write-complete pulse
//   o_mem_addr/o_mem_we/o_mem_wdata   byte memory address, write enable, data
//   i_mem_rdata                       byte read data, combinational from addr
//
// Parameters: AWIDTH memory byte-address width; DWIDTH memory width (8 only).
// Build option: IMEM_ARB_FETCH_PRIO_EN defined gives fetch fixed priority on
// simultaneous requests; undefined gives round-robin.
module imem_arbiter #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_f_req,
  input  logic [31:0]       i_f_addr,
  output logic              o_f_gnt,
  output logic              o_f_valid,
  output logic [31:0]       o_f_rdata,
  input  logic              i_l_req,
  input  logic [31:0]       i_l_addr,
  input  logic [31:0]       i_l_wdata,
  output logic              o_l_gnt,
  output logic              o_l_done,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DWIDTH-1:0] o_mem_wdata,
  input  logic [DWIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        cnt;
  logic              last_byte;
  logic [AWIDTH-3:0] word_addr;
  logic [31:0]       wbuf;
  logic [23:0]       rbuf;
  logic              fetch_wins;

  // Word-aligned address only; low byte offset and high bits are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_f_addr[31:AWIDTH], i_f_addr[1:0],
                              i_l_addr[31:AWIDTH], i_l_addr[1:0]};

  assign last_byte = (cnt == 2'd3);

`ifdef IMEM_ARB_FETCH_PRIO_EN
  assign fetch_wins = 1'b1;
`else
  // Round-robin pointer: set means fetch wins the next tie.
  logic rr_fetch;
  always_ff @(posedge i_clk) begin
    if (i_rst)        rr_fetch <= 1'b1;
    else if (o_f_gnt) rr_fetch <= 1'b0;
    else if (o_l_gnt) rr_fetch <= 1'b1;
  end
  assign fetch_wins = rr_fetch;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and grants.
  always_comb begin
    state_nxt = state;
    o_f_gnt   = 1'b0;
    o_l_gnt   = 1'b0;
    case (state)
      IDLE: begin
        if (i_f_req && (fetch_wins || !i_l_req)) begin
          o_f_gnt   = 1'b1;
          state_nxt = READ;
        end else if (i_l_req) begin
          o_l_gnt   = 1'b1;
          state_nxt = WRITE;
        end
      end
      READ, WRITE: begin
        if (last_byte) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte counter, request capture, read assembly and completion pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= 2'd0;
      word_addr <= '0;
      wbuf      <= 32'd0;
      rbuf      <= 24'd0;
      o_f_rdata <= 32'd0;
      o_f_valid <= 1'b0;
      o_l_done  <= 1'b0;
    end else begin
      o_f_valid <= (state == READ) && last_byte;
      o_l_done  <= (state == WRITE) && last_byte;
      if (state == IDLE) begin
        cnt <= 2'd0;
        if (o_f_gnt) begin
          word_addr <= i_f_addr[AWIDTH-1:2];
        end else if (o_l_gnt) begin
          word_addr <= i_l_addr[AWIDTH-1:2];
          wbuf      <= i_l_wdata;
        end
      end else begin
        cnt <= cnt + 2'd1;
      end
      // Bytes arrive MSB first, so shifting left leaves byte 0 on top.
      if (state == READ) begin
        rbuf <= {rbuf[15:0], i_mem_rdata};
        if (last_byte) o_f_rdata <= {rbuf, i_mem_rdata};
      end
    end
  end

  assign o_mem_addr  = (state == IDLE) ? '0 : {word_addr, cnt};
  // Reset suppresses the write on the aborting edge itself.
  assign o_mem_we    = (state == WRITE) && !i_rst;
  // ~cnt is 3-cnt: counter 0 selects bits [31:24].
  assign o_mem_wdata = (state == WRITE) ? wbuf[{~cnt, 3'b000} +: 8] : '0;

endmodule
